// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one combinational ALU between two
// requesters, with registered ALU drive and a tagged valid/ready response.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   reqN_valid/instr/rs/rt  requester N operation (N = 0, 1)
//   reqN_ready              requester N accepted this cycle (combinational)
//   resp_valid/ready        response handshake
//   resp_id/result/branch   owner, captured ALU_result, captured sig_branch
//   opcode .. immediate     registered drive into the shared ALU
//   ALU_result, sig_branch  combinational ALU outputs
//   busy                    state is not IDLE
//   op_count                completed response handshakes (wrapping)
module alu_share_arbiter #(
   parameter int ALU_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic [31:0]      req0_instr,
   input  logic [31:0]      req0_rs,
   input  logic [31:0]      req0_rt,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [31:0]      req1_instr,
   input  logic [31:0]      req1_rs,
   input  logic [31:0]      req1_rt,
   output logic             req1_ready,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [31:0]      resp_result,
   output logic             resp_branch,
   output logic [5:0]       opcode,
   output logic [31:0]      rs_content,
   output logic [31:0]      rt_content,
   output logic [4:0]       shamt,
   output logic [5:0]       ALU_control,
   output logic [15:0]      immediate,
   input  logic [31:0]      ALU_result,
   input  logic             sig_branch,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // EXEC lasts ALU_LAT+1 cycles so the result is sampled one full
   // settle window after the drive registers update.
   localparam logic [4:0] LP_LOAD = 5'(ALU_LAT + 1);

   state_t      r_state;
   logic        r_ptr;
   logic        r_gid;
   logic [4:0]  r_cnt;

   logic        w_idle;
   logic        w_gnt0;
   logic        w_gnt1;
   logic [31:0] w_instr;
   logic [31:0] w_rs;
   logic [31:0] w_rt;
   logic        w_unused;

   assign w_idle = (r_state == S_IDLE) && rst_n;

   // Pointer only breaks ties; a lone valid requester always wins.
   assign w_gnt0 = w_idle && req0_valid && (!req1_valid || !r_ptr);
   assign w_gnt1 = w_idle && req1_valid && (!req0_valid || r_ptr);

   assign req0_ready = w_gnt0;
   assign req1_ready = w_gnt1;

   assign w_instr = w_gnt1 ? req1_instr : req0_instr;
   assign w_rs    = w_gnt1 ? req1_rs    : req0_rs;
   assign w_rt    = w_gnt1 ? req1_rt    : req0_rt;

   // Register-number fields are not needed: operands arrive as contents.
   assign w_unused = ^w_instr[25:16];

   assign busy = (r_state != S_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_ptr       <= 1'b0;
         r_gid       <= 1'b0;
         r_cnt       <= 5'd0;
         op_count    <= '0;
         opcode      <= 6'd0;
         rs_content  <= 32'd0;
         rt_content  <= 32'd0;
         shamt       <= 5'd0;
         ALU_control <= 6'd0;
         immediate   <= 16'd0;
         resp_valid  <= 1'b0;
         resp_id     <= 1'b0;
         resp_result <= 32'd0;
         resp_branch <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_gnt0 || w_gnt1) begin
                  opcode      <= w_instr[31:26];
                  rs_content  <= w_rs;
                  rt_content  <= w_rt;
                  shamt       <= w_instr[10:6];
                  ALU_control <= w_instr[5:0];
                  immediate   <= w_instr[15:0];
                  r_gid       <= w_gnt1;
                  r_cnt       <= LP_LOAD;
                  r_state     <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_cnt <= r_cnt - 5'd1;
               if (r_cnt == 5'd1) begin
                  resp_result <= ALU_result;
                  resp_branch <= sig_branch;
                  resp_id     <= r_gid;
                  resp_valid  <= 1'b1;
                  r_state     <= S_RESP;
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  op_count   <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
                  r_ptr      <= ~r_gid;
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
